// File: rtl/calc_cmd_sequencer.sv
// Command front-end for the 8-bit calculator core: parses header/A/B byte packets,
// pulses the core enable once, captures its result and hands it downstream.
// Optional inter-byte timeout compiled in with `define CALC_SEQ_TIMEOUT_EN.
module calc_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       calc_a,
  output logic [7:0]       calc_b,
  output logic [1:0]       calc_modo,
  output logic             calc_enb,
  input  logic [7:0]       calc_c,
  output logic [7:0]       res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             hdr_err,
  output logic             to_err,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic hdr_ok;
  logic collecting;
  logic timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("calc_cmd_sequencer: TIMEOUT_CYCLES must be within 1..65535");
  end

  assign in_ready   = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign accept     = in_valid && in_ready;
  assign hdr_ok     = (in_data[7:2] == 6'd0);
  assign collecting = (state == GET_A) || (state == GET_B);

  assign calc_enb  = (state == ISSUE);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt;

  // Counts stalled cycles while a packet is partially received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (collecting && !accept && !timeout) begin
      idle_cnt <= idle_cnt + 16'd1;
    end else begin
      idle_cnt <= '0;
    end
  end

  assign timeout = collecting && !accept && (idle_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && hdr_ok) state_nxt = GET_A;
      end
      GET_A: begin
        if (accept)       state_nxt = GET_B;
        else if (timeout) state_nxt = IDLE;
      end
      GET_B: begin
        if (accept)       state_nxt = ISSUE;
        else if (timeout) state_nxt = IDLE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The core zeroes c whenever enb is low, so the result only exists during WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_a    <= '0;
      calc_b    <= '0;
      calc_modo <= '0;
      res_data  <= '0;
      hdr_err   <= 1'b0;
      to_err    <= 1'b0;
      cmd_cnt   <= '0;
    end else begin
      hdr_err <= (state == IDLE) && accept && !hdr_ok;
      to_err  <= timeout;
      if ((state == IDLE) && accept && hdr_ok) calc_modo <= in_data[1:0];
      if ((state == GET_A) && accept)          calc_a    <= in_data;
      if ((state == GET_B) && accept)          calc_b    <= in_data;
      if (state == WAIT)                       res_data  <= calc_c;
      if ((state == RESP) && res_ready)        cmd_cnt   <= cmd_cnt + 1'b1;
    end
  end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
- Front-end stage directly upstream of the 8-bit calculator core. It drives that core's a, b, MODO and enb inputs and captures its registered c output.
- Receives 3-byte command packets over a valid/ready byte stream: header, operand A, operand B.
- For each packet: issues a one-cycle enable pulse to the core, captures the result on the following cycle, and returns it on a valid/ready result interface.
- Serialises all traffic to the core, so only one command is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255: inter-byte timeout limit in cycles. Used only when the optional feature is compiled in. Legal range 1..65535.
- CNT_W, 16: width of the completed-command counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  command stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- calc_a  out  8  operand A to the core.
- calc_b  out  8  operand B to the core.
- calc_modo  out  2  operation code to the core: 00 add, 01 sub, 10 mul, 11 shift-left.
- calc_enb  out  1  one-cycle enable pulse to the core.
- calc_c  in  8  registered result from the core.
- res_data  out  8  captured result.
- res_valid  out  1  res_data is valid.
- res_ready  in  1  downstream accepts the result.
- hdr_err  out  1  one-cycle pulse when a header is rejected.
- to_err  out  1  one-cycle pulse when a packet is aborted by timeout.
- cmd_cnt  out  CNT_W  number of completed commands; wraps modulo 2^CNT_W.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, rst=1): state IDLE. All of the following are 0: calc_a, calc_b, calc_modo, calc_enb, res_data, res_valid, hdr_err, to_err, cmd_cnt, busy.
- Byte acceptance: a byte is accepted on a clock edge only when in_valid=1 and in_ready=1.
- in_ready is 1 only in IDLE, GET_A and GET_B. It is combinational from state and does not depend on in_valid.
- IDLE: on an accepted byte, check the header.
  - If header[7:2]==0: latch header[1:0] into calc_modo and go to GET_A.
  - Otherwise: drop the byte, pulse hdr_err for 1 cycle, stay in IDLE.
- GET_A: on an accepted byte, latch it into calc_a and go to GET_B.
- GET_B: on an accepted byte, latch it into calc_b and go to ISSUE.
- ISSUE, exactly 1 cycle: calc_enb=1. calc_a, calc_b and calc_modo are stable. Go to WAIT.
- WAIT, exactly 1 cycle: calc_enb=0. At this edge, register calc_c into res_data and go to RESP.
  - The core forces c to 0 whenever enb=0, so calc_c is valid only in WAIT and must be captured then.
- RESP: res_valid=1 and res_data is held stable.
  - When res_ready=1: clear res_valid, increment cmd_cnt, go to IDLE.
  - No new header is accepted in RESP; in_ready=0.
- Latency: B byte accepted at edge N -> calc_enb high during cycle N+1 -> res_valid high from cycle N+3. With res_ready tied high, one command completes every 6 cycles or more.
- Operands hold their last values after a command completes. The core sees no enable outside ISSUE.
- Arithmetic is performed by the core. This block passes bytes through unmodified.
- Simultaneous events: res_ready asserted in the same cycle res_valid first rises completes the handshake that cycle.
- cmd_cnt wrap-around: all ones + 1 -> 0, with no flag.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A partial packet is discarded. A pending result is lost and cmd_cnt is cleared.

Optional Feature:
- Macro: CALC_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in GET_A and GET_B and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES without an accepted byte: pulse to_err for 1 cycle, return to IDLE, discard the partial packet. The counter resets.
  - ISSUE, WAIT and RESP are never timed out.
- Undefined: no counter. GET_A and GET_B wait indefinitely. to_err is tied to 0.

Test Plan:
1. Add: stream 0x00,0x12,0x34 with in_valid held high and res_ready=1 -> calc_enb pulses exactly once; res_data=0x46; res_valid for 1 cycle; cmd_cnt=1.
2. Mixed operations: packets sub {0x01,0x05,0x07}, mul {0x02,0x10,0x11}, shift {0x03,0x01,0x03} -> results 0xFE, 0x10, 0x08 in order; cmd_cnt increments by 3.
3. Backpressure: res_ready=0 for 10 cycles after res_valid rises -> res_data stays stable, in_ready stays 0, extra stream bytes are not consumed; release -> cmd_cnt increments once.
4. Bad header: byte 0x84 -> hdr_err pulses once and state stays IDLE; a following valid packet {0x00,0x01,0x01} -> result 0x02.
5. Reset mid-packet: assert rst asynchronously after the A byte -> all outputs 0 immediately; next full packet {0x00,0x02,0x03} -> result 0x05.
6. With CALC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: header 0x00, then no bytes for 8 cycles -> to_err pulses and state is IDLE; a following packet {0x00,0x07,0x01} -> result 0x08.
